fpu_mul_arbiter: RTL
====================

// Module: fpu_mul_arbiter
// PURPOSE
//  Shares one single-precision multiplier (stb/ack operand and result handshakes) between N requesters.
//  Round-robin grant; one operation in flight at a time.
//  Per grant: latches the operand pair, drives the multiplier handshake, captures the result,
//  then returns the result to the granted requester.
//  Sits between compute clients and the multiplier instance.
// PARAMETERS
//  N_REQ  4   number of requesters, 2..8
//  IDW    2   width of grant_id, $clog2(N_REQ)
// PORTS
//  clk           in   1         clock, rising edge
//  rst           in   1         asynchronous, active-low reset (0 = reset)
//  req_stb       in   N_REQ     per-requester operand-valid; held with operands until its req_ack
//  req_a         in   N_REQ*32  operand A, requester i at [32*i+:32]
//  req_b         in   N_REQ*32  operand B, same packing
//  req_ack       out  N_REQ     one-cycle pulse: operands of requester i accepted
//  res_z         out  32        result to granted requester
//  res_stb       out  N_REQ     result valid for requester i; held until res_ack[i]
//  res_ack       in   N_REQ     result consumed
//  busy          out  1         high in every state except IDLE
//  grant_id      out  IDW       index of current or last granted requester
//  mul_a         out  32        to multiplier input_a
//  mul_a_stb     out  1         to multiplier input_a_stb
//  mul_a_ack     in   1         from multiplier input_a_ack
//  mul_b         out  32        to multiplier input_b
//  mul_b_stb     out  1         to multiplier input_b_stb
//  mul_b_ack     in   1         from multiplier input_b_ack
//  mul_z         in   32        from multiplier output_z
//  mul_z_stb     in   1         from multiplier output_z_stb
//  mul_z_ack     out  1         to multiplier output_z_ack
// BEHAVIOUR
//  - Reset (async, rst=0): state=IDLE; all outputs 0; rr pointer=N_REQ-1 so requester 0 wins first.
//    Multiplier shares this reset. A reset mid-operation abandons the transaction with no result delivered.
//  - All outputs are registered.
//  - FSM states: IDLE, SEND, WAIT_Z, ACK_Z, DELIVER.
//  - IDLE: if any req_stb, pick the first set bit scanning from ptr+1 upward with wrap.
//    At that edge: latch a/b into mul_a/mul_b; grant_id<=i; ptr<=i; req_ack[i]<=1 for exactly one cycle;
//    mul_a_stb<=1; mul_b_stb<=1; go to SEND. No request: stay in IDLE.
//  - SEND: each stb is cleared independently on the edge after its ack is sampled high (flags a_done/b_done).
//    Acks may arrive in either order or the same cycle.
//    When both are done, go to WAIT_Z. mul_a/mul_b stay stable throughout SEND.
//  - WAIT_Z: on mul_z_stb=1, latch res_z<=mul_z and mul_z_ack<=1; go to ACK_Z. There is no timeout.
//  - ACK_Z: mul_z_ack held 1 for this one cycle only, then cleared.
//    res_stb[grant_id]<=1; go to DELIVER.
//  - DELIVER: hold res_z and res_stb[grant_id] until res_ack[grant_id]=1.
//    On that edge, clear res_stb; go to IDLE.
//    res_ack on non-granted bits is ignored.
//  - Arbitration is evaluated only in IDLE. New req_stb edges arriving while busy wait, and are not lost while held.
//    A requester must not drop req_stb before its req_ack.
//  - Fairness: a continuously requesting client is granted within N_REQ operations.
//  - Back-to-back: IDLE is re-entered for one cycle between operations (min 1 idle cycle).
//  - Latency from req_stb sampled to req_ack is 1 cycle. Latency from mul_z_stb sampled to res_stb is 2 cycles.
//  - At most one bit of req_ack and of res_stb is set at any time.
// TESTING
//  1 Reset: hold rst=0 for 3 cycles with req_stb=4'b1111 -> all outputs 0, busy=0, no req_ack.
//  2 Single op: req0 a=40866666 b=41280000 (4.2*10.5) -> req_ack[0] 1 cycle later; res_stb[0] with res_z=42306666 (44.1); busy drops after res_ack[0].
//  3 Contention: req1 (418e3333 x 421ce3a3) and req3 (40866666 x 41280000) raised in the same cycle
//    -> req1 is served first with res_z=442e4b4a, then req3 with res_z=42306666; grant_id goes 1 then 3.
//  4 Round-robin: all 4 requesters held high for 8 operations -> grant order 0,1,2,3,0,1,2,3.
//  5 Handshake skew: delay mul_b_ack 5 cycles after mul_a_ack, and hold res_ack low 10 cycles
//    -> mul_b_stb stays high until its ack; res_stb/res_z stable for the whole wait; mul_z_ack is a single pulse.
//  6 Mid-op reset: drop rst during WAIT_Z -> immediate return to IDLE with outputs 0;
//    the next request completes correctly.

Source files
------------

// File: rtl/fpu_mul_arbiter.sv
// Round-robin arbiter that shares one stb/ack single-precision multiplier between N_REQ clients.
// One operation in flight; operands latched at grant, result held until the owner acknowledges it.
module fpu_mul_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N_REQ-1:0]    req_stb_i,
  input  logic [N_REQ*32-1:0] req_a_i,
  input  logic [N_REQ*32-1:0] req_b_i,
  output logic [N_REQ-1:0]    req_ack_o,
  output logic [31:0]         res_z_o,
  output logic [N_REQ-1:0]    res_stb_o,
  input  logic [N_REQ-1:0]    res_ack_i,
  output logic                busy_o,
  output logic [IDW-1:0]      grant_id_o,
  output logic [31:0]         mul_a_o,
  output logic                mul_a_stb_o,
  input  logic                mul_a_ack_i,
  output logic [31:0]         mul_b_o,
  output logic                mul_b_stb_o,
  input  logic                mul_b_ack_i,
  input  logic [31:0]         mul_z_i,
  input  logic                mul_z_stb_i,
  output logic                mul_z_ack_o
);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_Z,
    ACK_Z,
    DELIVER
  } state_t;

  state_t             state_q;
  logic [IDW-1:0]     ptr_q;
  logic [IDW-1:0]     grant_q;
  logic [N_REQ-1:0]   req_ack_q;
  logic [N_REQ-1:0]   res_stb_q;
  logic [31:0]        res_z_q;
  logic [31:0]        mul_a_q;
  logic [31:0]        mul_b_q;
  logic               busy_q;
  logic               mul_a_stb_q;
  logic               mul_b_stb_q;
  logic               mul_z_ack_q;
  logic               a_done_q;
  logic               b_done_q;

  logic [31:0]        req_a_w [N_REQ];
  logic [31:0]        req_b_w [N_REQ];
  logic [IDW-1:0]     cand_idx [N_REQ];
  logic [N_REQ-1:0]   cand_hit;
  logic [N_REQ-1:0]   pick_onehot;
  logic [N_REQ-1:0]   grant_onehot;
  logic               pick_valid_d;
  logic [IDW-1:0]     pick_idx_d;
  logic               a_done_d;
  logic               b_done_d;

  // cand_idx[k] is the requester examined k-th, starting just after the last grant.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      logic [IDW:0] sum;
      assign sum           = {1'b0, ptr_q} + (IDW+1)'(gi + 1);
      assign cand_idx[gi]  = (sum >= (IDW+1)'(N_REQ)) ? IDW'(sum - (IDW+1)'(N_REQ))
                                                       : sum[IDW-1:0];
      assign cand_hit[gi]  = req_stb_i[cand_idx[gi]];
      assign req_a_w[gi]   = req_a_i[32*gi +: 32];
      assign req_b_w[gi]   = req_b_i[32*gi +: 32];
      assign pick_onehot[gi]  = (pick_idx_d == IDW'(gi));
      assign grant_onehot[gi] = (grant_q == IDW'(gi));
    end
  endgenerate

  // Lowest scan position wins, so iterate from the far end and let nearer hits overwrite.
  always_comb begin
    pick_valid_d = 1'b0;
    pick_idx_d   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        pick_valid_d = 1'b1;
        pick_idx_d   = cand_idx[k];
      end
    end
  end

  assign a_done_d = a_done_q | (mul_a_stb_q & mul_a_ack_i);
  assign b_done_d = b_done_q | (mul_b_stb_q & mul_b_ack_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ptr_q       <= IDW'(N_REQ - 1);
      grant_q     <= '0;
      req_ack_q   <= '0;
      res_stb_q   <= '0;
      res_z_q     <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      busy_q      <= 1'b0;
      mul_a_stb_q <= 1'b0;
      mul_b_stb_q <= 1'b0;
      mul_z_ack_q <= 1'b0;
      a_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
    end else begin
      req_ack_q   <= '0;
      mul_z_ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_valid_d) begin
            mul_a_q     <= req_a_w[pick_idx_d];
            mul_b_q     <= req_b_w[pick_idx_d];
            grant_q     <= pick_idx_d;
            ptr_q       <= pick_idx_d;
            req_ack_q   <= pick_onehot;
            mul_a_stb_q <= 1'b1;
            mul_b_stb_q <= 1'b1;
            a_done_q    <= 1'b0;
            b_done_q    <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= SEND;
          end
        end
        SEND: begin
          a_done_q <= a_done_d;
          b_done_q <= b_done_d;
          if (a_done_d) mul_a_stb_q <= 1'b0;
          if (b_done_d) mul_b_stb_q <= 1'b0;
          if (a_done_d && b_done_d) state_q <= WAIT_Z;
        end
        WAIT_Z: begin
          if (mul_z_stb_i) begin
            res_z_q     <= mul_z_i;
            mul_z_ack_q <= 1'b1;
            state_q     <= ACK_Z;
          end
        end
        ACK_Z: begin
          res_stb_q <= grant_onehot;
          state_q   <= DELIVER;
        end
        DELIVER: begin
          if (res_ack_i[grant_q]) begin
            res_stb_q <= '0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ack_o   = req_ack_q;
  assign res_z_o     = res_z_q;
  assign res_stb_o   = res_stb_q;
  assign busy_o      = busy_q;
  assign grant_id_o  = grant_q;
  assign mul_a_o     = mul_a_q;
  assign mul_a_stb_o = mul_a_stb_q;
  assign mul_b_o     = mul_b_q;
  assign mul_b_stb_o = mul_b_stb_q;
  assign mul_z_ack_o = mul_z_ack_q;

endmodule
